// File: rtl/video_pkg.sv
// video_pkg: shared video timing, VRAM geometry, pixel type and fill FSM state encoding
package video_pkg;
    localparam int H_ACTIVE    = 1280;
    localparam int V_ACTIVE    = 720;
    localparam int VRAM_SCALE  = 3;
    localparam int VRAM_WIDTH  = H_ACTIVE >> VRAM_SCALE;
    localparam int VRAM_HEIGHT = V_ACTIVE >> VRAM_SCALE;
    typedef logic [23:0] rgb24_t;
    typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_e;
    // Polarity swaps which half gets colour A.
    function automatic rgb24_t split_color(input logic right, input logic pol,
                                           input rgb24_t color_a, input rgb24_t color_b);
        return (right ^ pol) ? color_a : color_b;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser plus stability counter producing a clean level and change strobe
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic level_o,
    output logic edge_o
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic          sync1_q, sync2_q, level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // Count only while the synchronised input disagrees with the held level.
    always_comb begin
        edge_o  = (sync2_q != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        cnt_d   = (sync2_q == level_q || edge_o) ? '0 : cnt_q + CW'(1);
        level_d = edge_o ? sync2_q : level_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end
    assign level_o = level_q;
endmodule

// File: rtl/vram_fill_engine.sv
// vram_fill_engine: debounced button triggers a row-major left/right split fill of the VRAM
module vram_fill_engine #(
    parameter int                  VRAM_WIDTH      = video_pkg::VRAM_WIDTH,
    parameter int                  VRAM_HEIGHT     = video_pkg::VRAM_HEIGHT,
    parameter int                  ADDR_W          = 15,
    parameter int                  DEBOUNCE_CYCLES = 270000,
    parameter video_pkg::rgb24_t   COLOR_A         = 24'hFFFFFF,
    parameter video_pkg::rgb24_t   COLOR_B         = 24'h000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_raw,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              fill_done,
    output logic              btn_level
);
    import video_pkg::fill_state_e;
    import video_pkg::IDLE;
    import video_pkg::FILL;
    import video_pkg::DONE;
    import video_pkg::split_color;
    localparam int XW = VRAM_WIDTH > 1 ? $clog2(VRAM_WIDTH) : 1;
    localparam int YW = VRAM_HEIGHT > 1 ? $clog2(VRAM_HEIGHT) : 1;
    fill_state_e       state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pol_q, pol_d, pending_q, pending_d;
    logic              btn_edge, accept, x_last, last, start;
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_raw_i (btn_raw),
        .level_o   (btn_level),
        .edge_o    (btn_edge)
    );
    // A fill may start from IDLE or straight out of DONE; edges during FILL just queue.
    always_comb begin
        accept    = (state_q == FILL) && wr_ready;
        x_last    = x_q == XW'(VRAM_WIDTH - 1);
        last      = x_last && (y_q == YW'(VRAM_HEIGHT - 1));
        start     = pending_q && (state_q != FILL);
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        addr_d    = addr_q;
        pol_d     = pol_q;
        pending_d = btn_edge | (pending_q & ~start);
        if (start) begin
            state_d = FILL;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
            pol_d   = btn_level;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else if (accept) begin
            x_d     = x_last ? '0 : x_q + XW'(1);
            y_d     = x_last ? y_q + YW'(1) : y_q;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = last ? DONE : FILL;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            addr_q    <= '0;
            pol_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            addr_q    <= addr_d;
            pol_q     <= pol_d;
            pending_q <= pending_d;
        end
    end
    assign wr_en     = state_q == FILL;
    assign busy      = state_q == FILL;
    assign fill_done = state_q == DONE;
    assign wr_addr   = addr_q;
    assign wr_data   = wr_en ? split_color(x_q > XW'(VRAM_WIDTH / 2), pol_q, COLOR_A, COLOR_B) : '0;
endmodule

// File: tb/tb_vram_fill_engine.sv
// tb_vram_fill_engine: directed scenario tasks for the VRAM fill engine on an 8x4 frame
module tb_vram_fill_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_raw = 1'b1;
    logic        wr_ready = 1'b1;
    logic        wr_en, busy, fill_done, btn_level;
    logic [14:0] wr_addr;
    logic [23:0] wr_data;
    int          n_checks = 0;
    int          n_fail = 0;

    vram_fill_engine #(
        .VRAM_WIDTH(8), .VRAM_HEIGHT(4), .ADDR_W(15), .DEBOUNCE_CYCLES(4),
        .COLOR_A(24'hFFFFFF), .COLOR_B(24'h000000)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy), .fill_done(fill_done),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] exp_data(input int idx, input bit pol);
        bit right;
        right = (idx % 8) >= 5;
        return (right != pol) ? 24'hFFFFFF : 24'h000000;
    endfunction

    // Follows one fill from the current cycle until fill_done, tallying ordering/stall errors.
    task automatic collect_fill(input bit pol, input bit bp, input int release_at,
                                output int n_wr, output int n_bad, output int n_done,
                                output int wr_at_done, output int n_stall);
        bit          prev_stall;
        logic [14:0] prev_addr;
        logic [23:0] prev_data;
        n_wr = 0; n_bad = 0; n_done = 0; wr_at_done = -1; n_stall = 0;
        prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
        for (int c = 0; c < 400; c++) begin
            if (fill_done) begin
                n_done++;
                wr_at_done = n_wr;
                break;
            end
            wr_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            if (prev_stall && (!wr_en || wr_addr !== prev_addr || wr_data !== prev_data)) begin
                n_bad++;
                $display("  stall drift: en %b addr %0d data %h held %0d %h", wr_en, wr_addr, wr_data, prev_addr, prev_data);
            end
            prev_stall = wr_en && !wr_ready;
            if (prev_stall) n_stall++;
            prev_addr = wr_addr;
            prev_data = wr_data;
            if (wr_en && wr_ready) begin
                if (wr_addr !== 15'(n_wr) || wr_data !== exp_data(n_wr, pol)) begin
                    n_bad++;
                    $display("  write %0d: addr %0d data %h expected addr %0d data %h", n_wr, wr_addr, wr_data, n_wr, exp_data(n_wr, pol));
                end
                if (n_wr == release_at) btn_raw = 1'b1;
                n_wr++;
            end
            tick();
        end
        wr_ready = 1'b1;
    endtask

    task automatic test_reset();
        int writes;
        rst = 1'b1; btn_raw = 1'b1; wr_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (btn_level !== 1'b1) begin n_fail++; $display("FAIL reset_btn_level: got %b want 1", btn_level); end
        n_checks++; if (fill_done !== 1'b0 || wr_addr !== 15'd0 || wr_data !== 24'h0) begin
            n_fail++; $display("FAIL reset_outputs: got done %b addr %0d data %h want 0 0 000000", fill_done, wr_addr, wr_data);
        end
        writes = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (wr_en) writes++;
        end
        n_checks++; if (writes !== 0) begin n_fail++; $display("FAIL reset_idle_writes: got %0d want 0", writes); end
    endtask

    task automatic test_glitch();
        int writes;
        int lvl_low;
        btn_raw = 1'b0;
        repeat (3) tick();
        btn_raw = 1'b1;
        writes = 0; lvl_low = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (wr_en) writes++;
            if (!btn_level) lvl_low++;
        end
        n_checks++; if (lvl_low !== 0) begin n_fail++; $display("FAIL glitch_level: got %0d low cycles want 0", lvl_low); end
        n_checks++; if (writes !== 0) begin n_fail++; $display("FAIL glitch_writes: got %0d want 0", writes); end
    endtask

    task automatic test_press();
        int n_wr, n_bad, n_done, at_done, n_stall, extra;
        btn_raw = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 5) begin
                n_checks++; if (btn_level !== 1'b1) begin n_fail++; $display("FAIL press_level_early: got %b want 1", btn_level); end
            end
        end
        n_checks++; if (btn_level !== 1'b0) begin n_fail++; $display("FAIL press_level: got %b want 0", btn_level); end
        collect_fill(1'b0, 1'b0, -1, n_wr, n_bad, n_done, at_done, n_stall);
        n_checks++; if (n_wr !== 32) begin n_fail++; $display("FAIL press_write_count: got %0d want 32", n_wr); end
        n_checks++; if (n_bad !== 0) begin n_fail++; $display("FAIL press_write_content: got %0d bad want 0", n_bad); end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL press_fill_done: got %0d want 1", n_done); end
        tick();
        n_checks++; if (fill_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL press_after_done: got done %b busy %b want 0 0", fill_done, busy);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wr_en || fill_done) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL press_quiet_after: got %0d want 0", extra); end
    endtask

    task automatic test_backpressure();
        int n_wr, n_bad, n_done, at_done, n_stall;
        btn_raw = 1'b1;
        collect_fill(1'b1, 1'b1, -1, n_wr, n_bad, n_done, at_done, n_stall);
        n_checks++; if (n_wr !== 32) begin n_fail++; $display("FAIL bp_write_count: got %0d want 32", n_wr); end
        n_checks++; if (n_bad !== 0) begin n_fail++; $display("FAIL bp_stable_order: got %0d bad want 0", n_bad); end
        n_checks++; if (at_done !== 32) begin n_fail++; $display("FAIL bp_done_after_last: got %0d writes want 32", at_done); end
        n_checks++; if (n_stall < 1) begin n_fail++; $display("FAIL bp_stalls_seen: got %0d want >0", n_stall); end
        repeat (5) tick();
    endtask

    task automatic test_release_during_fill();
        int n_wr, n_bad, n_done, at_done, n_stall;
        btn_raw = 1'b0;
        collect_fill(1'b0, 1'b0, 10, n_wr, n_bad, n_done, at_done, n_stall);
        n_checks++; if (n_wr !== 32 || at_done !== 32) begin
            n_fail++; $display("FAIL rel_first_fill: got %0d writes done at %0d want 32 32", n_wr, at_done);
        end
        n_checks++; if (n_bad !== 0 || n_done !== 1) begin
            n_fail++; $display("FAIL rel_first_content: got %0d bad %0d done want 0 1", n_bad, n_done);
        end
        tick();
        n_checks++; if (busy !== 1'b1 || wr_addr !== 15'd0 || wr_data !== 24'hFFFFFF) begin
            n_fail++; $display("FAIL rel_restart: got busy %b addr %0d data %h want 1 0 ffffff", busy, wr_addr, wr_data);
        end
        collect_fill(1'b1, 1'b0, -1, n_wr, n_bad, n_done, at_done, n_stall);
        n_checks++; if (n_wr !== 32 || n_bad !== 0 || n_done !== 1) begin
            n_fail++; $display("FAIL rel_second_fill: got %0d writes %0d bad %0d done want 32 0 1", n_wr, n_bad, n_done);
        end
        repeat (5) tick();
    endtask

    task automatic test_reset_mid_fill();
        int n_wr, n_bad, n_done, at_done, n_stall;
        btn_raw = 1'b0;
        for (int c = 0; c < 200 && !(wr_en && wr_addr == 15'd17); c++) tick();
        n_checks++; if (!(wr_en && wr_addr == 15'd17)) begin
            n_fail++; $display("FAIL rst_reach_17: got en %b addr %0d want 1 17", wr_en, wr_addr);
        end
        rst = 1'b1; btn_raw = 1'b1;
        tick();
        n_checks++; if (wr_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_abort: got en %b busy %b want 0 0", wr_en, busy);
        end
        rst = 1'b0;
        repeat (10) tick();
        n_checks++; if (wr_en !== 1'b0 || btn_level !== 1'b1) begin
            n_fail++; $display("FAIL rst_idle: got en %b level %b want 0 1", wr_en, btn_level);
        end
        btn_raw = 1'b0;
        collect_fill(1'b0, 1'b0, -1, n_wr, n_bad, n_done, at_done, n_stall);
        n_checks++; if (n_wr !== 32 || n_bad !== 0 || n_done !== 1) begin
            n_fail++; $display("FAIL rst_refill: got %0d writes %0d bad %0d done want 32 0 1", n_wr, n_bad, n_done);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press();
        test_backpressure();
        test_release_during_fill();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
